// File: rtl/secded_err_monitor.sv
// Error-statistics stage behind the Hamming(7,4) SECDED decoder: saturating word/error counters,
// halt-on-uncorrectable FSM and an optional registered 7-segment readout (SECDED_MON_7SEG_EN).
module secded_err_monitor #(
    parameter int unsigned CNT_W          = 8,
    parameter bit          HALT_ON_UNCORR = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [3:0]       i_data,
    input  logic [3:0]       i_exp_data,
    input  logic             i_1bit_error,
    input  logic             i_2bit_error,
    input  logic             i_parity_error,
    input  logic             i_clear,
    input  logic [1:0]       i_sel,
    output logic [CNT_W-1:0] o_word_cnt,
    output logic [CNT_W-1:0] o_corr_cnt,
    output logic [CNT_W-1:0] o_uncorr_cnt,
    output logic [CNT_W-1:0] o_mismatch_cnt,
    output logic             o_sticky_uncorr,
    output logic             o_halted,
    output logic [3:0]       o_last_data,
    output logic [6:0]       o_7seg
);

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e           state_q, state_d;
    logic             s1_valid_q, s1_valid_d;
    logic [3:0]       s1_data_q, s1_exp_q;
    logic             s1_1bit_q, s1_2bit_q, s1_par_q;
    logic [CNT_W-1:0] word_q, word_d, corr_q, corr_d, uncorr_q, uncorr_d, mism_q, mism_d;
    logic             sticky_q, sticky_d;
    logic [3:0]       last_q, last_d;
    logic             accept, proc, halt_evt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        accept   = i_valid && (state_q != StHalt);
        // A word still in stage 1 when HALT is entered is discarded here.
        proc     = s1_valid_q && (state_q != StHalt);
        halt_evt = proc && s1_2bit_q && HALT_ON_UNCORR;

        state_d = state_q;
        unique case (state_q)
            StIdle:  if (i_valid) state_d = StRun;
            StRun:   if (halt_evt) state_d = StHalt;
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase

        s1_valid_d = accept;
        word_d     = word_q;
        corr_d     = corr_q;
        uncorr_d   = uncorr_q;
        mism_d     = mism_q;
        sticky_d   = sticky_q;
        last_d     = last_q;

        if (proc) begin
            word_d = sat_inc(word_q);
            last_d = s1_data_q;
            if (s1_2bit_q) begin
                uncorr_d = sat_inc(uncorr_q);
                sticky_d = 1'b1;
            end else begin
                if (s1_1bit_q || s1_par_q) corr_d = sat_inc(corr_q);
                if (s1_data_q != s1_exp_q) mism_d = sat_inc(mism_q);
            end
        end

        if (i_clear) begin
            state_d    = StIdle;
            s1_valid_d = 1'b0;
            word_d     = '0;
            corr_d     = '0;
            uncorr_d   = '0;
            mism_d     = '0;
            sticky_d   = 1'b0;
            last_d     = 4'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            s1_valid_q <= 1'b0;
            s1_data_q  <= 4'h0;
            s1_exp_q   <= 4'h0;
            s1_1bit_q  <= 1'b0;
            s1_2bit_q  <= 1'b0;
            s1_par_q   <= 1'b0;
            word_q     <= '0;
            corr_q     <= '0;
            uncorr_q   <= '0;
            mism_q     <= '0;
            sticky_q   <= 1'b0;
            last_q     <= 4'h0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            if (accept) begin
                s1_data_q <= i_data;
                s1_exp_q  <= i_exp_data;
                s1_1bit_q <= i_1bit_error;
                s1_2bit_q <= i_2bit_error;
                s1_par_q  <= i_parity_error;
            end
            word_q   <= word_d;
            corr_q   <= corr_d;
            uncorr_q <= uncorr_d;
            mism_q   <= mism_d;
            sticky_q <= sticky_d;
            last_q   <= last_d;
        end
    end

    assign o_word_cnt      = word_q;
    assign o_corr_cnt      = corr_q;
    assign o_uncorr_cnt    = uncorr_q;
    assign o_mismatch_cnt  = mism_q;
    assign o_sticky_uncorr = sticky_q;
    assign o_halted        = (state_q == StHalt);
    assign o_last_data     = last_q;

`ifdef SECDED_MON_7SEG_EN
    logic [3:0] digit;
    logic [6:0] seg_d, seg_q;

    always_comb begin
        unique case (i_sel)
            2'b00:   digit = word_q[3:0];
            2'b01:   digit = corr_q[3:0];
            2'b10:   digit = uncorr_q[3:0];
            default: digit = mism_q[3:0];
        endcase
        unique case (digit)
            4'h0: seg_d = 7'h3F;
            4'h1: seg_d = 7'h06;
            4'h2: seg_d = 7'h5B;
            4'h3: seg_d = 7'h4F;
            4'h4: seg_d = 7'h66;
            4'h5: seg_d = 7'h6D;
            4'h6: seg_d = 7'h7D;
            4'h7: seg_d = 7'h07;
            4'h8: seg_d = 7'h7F;
            4'h9: seg_d = 7'h6F;
            4'hA: seg_d = 7'h77;
            4'hB: seg_d = 7'h7C;
            4'hC: seg_d = 7'h39;
            4'hD: seg_d = 7'h5E;
            4'hE: seg_d = 7'h79;
            default: seg_d = 7'h71;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) seg_q <= 7'h3F;
        else        seg_q <= seg_d;
    end

    assign o_7seg = seg_q;
`else
    logic unused_sel;
    assign unused_sel = ^i_sel;
    assign o_7seg     = 7'h00;
`endif

endmodule

// File: tb/tb_secded_err_monitor.sv
// Scoreboard bench: two monitors (CNT_W=8 halting, CNT_W=4 non-halting) share stimulus and are
// checked each cycle against a behavioural counting model.
module tb_secded_err_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_valid = 1'b0, i_clear = 1'b0;
    logic [3:0] i_data = 4'h0, i_exp_data = 4'h0;
    logic       i_1bit_error = 1'b0, i_2bit_error = 1'b0, i_parity_error = 1'b0;
    logic [1:0] i_sel = 2'b00;

    logic [7:0] w8, c8, u8, m8;
    logic [3:0] w4, c4, u4, m4;
    logic       st8, h8, st4, h4;
    logic [3:0] last8, last4;
    logic [6:0] seg8, seg4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    secded_err_monitor #(.CNT_W(8), .HALT_ON_UNCORR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .i_exp_data(i_exp_data),
        .i_1bit_error(i_1bit_error), .i_2bit_error(i_2bit_error),
        .i_parity_error(i_parity_error), .i_clear(i_clear), .i_sel(i_sel),
        .o_word_cnt(w8), .o_corr_cnt(c8), .o_uncorr_cnt(u8), .o_mismatch_cnt(m8),
        .o_sticky_uncorr(st8), .o_halted(h8), .o_last_data(last8), .o_7seg(seg8)
    );

    secded_err_monitor #(.CNT_W(4), .HALT_ON_UNCORR(1'b0)) dut4 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .i_exp_data(i_exp_data),
        .i_1bit_error(i_1bit_error), .i_2bit_error(i_2bit_error),
        .i_parity_error(i_parity_error), .i_clear(i_clear), .i_sel(i_sel),
        .o_word_cnt(w4), .o_corr_cnt(c4), .o_uncorr_cnt(u4), .o_mismatch_cnt(m4),
        .o_sticky_uncorr(st4), .o_halted(h4), .o_last_data(last4), .o_7seg(seg4)
    );

    typedef struct {
        logic [15:0] w, c, u, m;
        logic        st, h;
        logic [3:0]  last;
        logic [6:0]  seg;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];

    // Reference model, one slot per instance: 0 = CNT_W 8 halting, 1 = CNT_W 4 free-running.
    localparam int MIdle = 0, MRun = 1, MHalt = 2;
    int         mw[2], mc[2], mu[2], mm[2], mmode[2];
    bit         mst[2], pend[2], p1[2], p2[2], pp[2];
    logic [3:0] mlast[2], pd[2], pe[2];
    logic [6:0] mseg[2];

    function automatic logic [6:0] seg_of(input int v);
`ifdef SECDED_MON_7SEG_EN
        logic [6:0] tab [16];
        tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return tab[v % 16];
`else
        return (v < 0) ? 7'h7F : 7'h00;
`endif
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mw[k] = 0; mc[k] = 0; mu[k] = 0; mm[k] = 0; mmode[k] = MIdle;
            mst[k] = 0; pend[k] = 0; mlast[k] = 4'h0; mseg[k] = seg_of(0);
        end
    endtask

    function automatic int bump(input int v, input int k);
        int cmax;
        cmax = (k == 0) ? 255 : 15;
        return (v < cmax) ? v + 1 : v;
    endfunction

    task automatic model_step(input int k, input bit v, input logic [3:0] d, input logic [3:0] e,
                              input bit f1, input bit f2, input bit fp, input bit clr,
                              input logic [1:0] sel);
        int  shown;
        bit  go_halt;
        int  next_mode;
        shown = (sel == 2'd0) ? mw[k] : (sel == 2'd1) ? mc[k] : (sel == 2'd2) ? mu[k] : mm[k];
        mseg[k] = seg_of(shown);
        if (clr) begin
            mw[k] = 0; mc[k] = 0; mu[k] = 0; mm[k] = 0; mst[k] = 0;
            mlast[k] = 4'h0; pend[k] = 0; mmode[k] = MIdle;
        end else begin
            go_halt = 0;
            if (pend[k] && mmode[k] != MHalt) begin
                mw[k] = bump(mw[k], k);
                mlast[k] = pd[k];
                if (p2[k]) begin
                    mu[k] = bump(mu[k], k);
                    mst[k] = 1;
                    go_halt = (k == 0);
                end else begin
                    if (p1[k] || pp[k]) mc[k] = bump(mc[k], k);
                    if (pd[k] != pe[k]) mm[k] = bump(mm[k], k);
                end
            end
            next_mode = mmode[k];
            if (mmode[k] == MIdle && v) next_mode = MRun;
            if (go_halt) next_mode = MHalt;
            pend[k] = v && (mmode[k] != MHalt);
            pd[k] = d; pe[k] = e; p1[k] = f1; p2[k] = f2; pp[k] = fp;
            mmode[k] = next_mode;
        end
    endtask

    function automatic exp_t snap(input int k);
        exp_t x;
        x.w = mw[k][15:0]; x.c = mc[k][15:0]; x.u = mu[k][15:0]; x.m = mm[k][15:0];
        x.st = mst[k]; x.h = (mmode[k] == MHalt); x.last = mlast[k]; x.seg = mseg[k];
        return x;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic cmp8(input exp_t x);
        chk("word8", {8'h0, w8}, x.w);      chk("corr8", {8'h0, c8}, x.c);
        chk("uncorr8", {8'h0, u8}, x.u);    chk("mism8", {8'h0, m8}, x.m);
        chk("sticky8", {15'h0, st8}, {15'h0, x.st});
        chk("halted8", {15'h0, h8}, {15'h0, x.h});
        chk("last8", {12'h0, last8}, {12'h0, x.last});
        chk("seg8", {9'h0, seg8}, {9'h0, x.seg});
    endtask

    task automatic cmp4(input exp_t x);
        chk("word4", {12'h0, w4}, x.w);     chk("corr4", {12'h0, c4}, x.c);
        chk("uncorr4", {12'h0, u4}, x.u);   chk("mism4", {12'h0, m4}, x.m);
        chk("sticky4", {15'h0, st4}, {15'h0, x.st});
        chk("halted4", {15'h0, h4}, {15'h0, x.h});
        chk("last4", {12'h0, last4}, {12'h0, x.last});
        chk("seg4", {9'h0, seg4}, {9'h0, x.seg});
    endtask

    // Monitor: outputs settle just after the edge that consumed the pushed stimulus.
    always @(posedge clk) begin
        #1;
        if (q8.size() > 0) cmp8(q8.pop_front());
        if (q4.size() > 0) cmp4(q4.pop_front());
    end

    task automatic drive(input bit v, input logic [3:0] d, input logic [3:0] e, input bit f1,
                         input bit f2, input bit fp, input bit clr, input logic [1:0] sel);
        @(negedge clk);
        i_valid = v; i_data = d; i_exp_data = e; i_1bit_error = f1; i_2bit_error = f2;
        i_parity_error = fp; i_clear = clr; i_sel = sel;
        for (int k = 0; k < 2; k++) model_step(k, v, d, e, f1, f2, fp, clr, sel);
        q8.push_back(snap(0));
        q4.push_back(snap(1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 4'h0, 4'h0, 0, 0, 0, 0, 2'b00);
    endtask

    task automatic clean(input logic [3:0] d);
        drive(1, d, d, 0, 0, 0, 0, 2'b00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_valid = 0; i_clear = 0; i_1bit_error = 0; i_2bit_error = 0; i_parity_error = 0;
        rst_n = 1'b0;
        #1;
        model_reset();
        cmp8(snap(0));
        cmp4(snap(1));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        cmp8(snap(0));
        cmp4(snap(1));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 1; i <= 5; i++) clean(4'(i));
        idle(2);
        drive(1, 4'h7, 4'h7, 1, 0, 0, 0, 2'b01);
        drive(1, 4'h3, 4'h3, 0, 0, 1, 0, 2'b01);
        idle(2);

        drive(0, 4'h0, 4'h0, 0, 0, 0, 1, 2'b00);
        drive(1, 4'hA, 4'h5, 1, 0, 0, 0, 2'b11);
        drive(1, 4'hA, 4'h5, 0, 1, 0, 0, 2'b11);
        for (int i = 0; i < 3; i++) clean(4'(i + 8));
        idle(2);
        drive(0, 4'h0, 4'h0, 0, 0, 0, 1, 2'b10);
        clean(4'hC);
        idle(2);

        drive(0, 4'h0, 4'h0, 0, 0, 0, 1, 2'b00);
        for (int i = 0; i < 10; i++) clean(4'(i));
        idle(2);
        for (int i = 0; i < 12; i++) clean(4'(i + 3));
        idle(2);

        drive(1, 4'h6, 4'h6, 0, 0, 0, 1, 2'b00);
        idle(2);
        clean(4'hE);
        clean(4'hD);
        do_reset();
        idle(1);

        for (int n = 0; n < 800; n++) begin
            logic [3:0] d, e;
            bit         v, f1, f2, fp, clr;
            int         r;
            v  = ($urandom_range(0, 3) != 0);
            d  = 4'($urandom);
            e  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : d;
            r  = $urandom_range(0, 11);
            f2 = (r == 0) || (r == 1);
            f1 = (r == 1) || (r == 2) || (r == 4);
            fp = (r == 3) || (r == 4);
            clr = ($urandom_range(0, 29) == 0);
            drive(v, d, e, f1, f2, fp, clr, 2'($urandom));
            if (n == 400) do_reset();
        end
        idle(2);
        @(negedge clk);
        checks++;
        if (q8.size() != 0 || q4.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d entries left, want 0", q8.size() + q4.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/secded_err_monitor.md
# secded_err_monitor

Error-statistics stage directly downstream of the SECDED Hamming(7,4) decoder. Samples each decoded nibble and its error flags on a valid strobe and compares the nibble against the expected source nibble. Keeps saturating counts of words, corrected errors, uncorrectable errors and silent mismatches. Optionally drives a 7-segment digit for on-board readout of a selected counter.

## Interface
- CNT_W, 8, width of every counter (4..16)
- HALT_ON_UNCORR, 1, 1 = stop counting after first uncorrectable word until cleared

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  decoder output word valid this cycle
- i_data  in  4  decoded nibble (decoder o_data)
- i_exp_data  in  4  nibble originally fed to the encoder
- i_1bit_error  in  1  decoder single-bit-corrected flag
- i_2bit_error  in  1  decoder double-bit-detected flag
- i_parity_error  in  1  decoder overall-parity-bit-only error flag
- i_clear  in  1  synchronous clear of counters, sticky flag and FSM
- i_sel  in  2  display select: 00 word, 01 corr, 10 uncorr, 11 mismatch
- o_word_cnt  out  CNT_W  words accepted
- o_corr_cnt  out  CNT_W  words with 1-bit or parity-only error, no 2-bit flag
- o_uncorr_cnt  out  CNT_W  words with 2-bit flag
- o_mismatch_cnt  out  CNT_W  words with i_data != i_exp_data and no 2-bit flag
- o_sticky_uncorr  out  1  set on first uncorrectable word
- o_halted  out  1  FSM in HALT
- o_last_data  out  4  nibble of last accepted word
- o_7seg  out  7  segments a..g on bits 0..6, active high

## Operation
- Stage 1: on i_valid in an accepting state, register i_data, i_exp_data and the three flags, and set s1_valid. Otherwise s1_valid = 0.
- Stage 2: when s1_valid is set:
  - Word: word_cnt +1, o_last_data <= data.
  - Uncorrectable: if 2-bit flag, uncorr_cnt +1 and sticky set.
  - Corrected: else if 1-bit or parity flag, corr_cnt +1.
  - Mismatch: if no 2-bit flag and data != exp, mismatch_cnt +1. This can coincide with a corr increment, i.e. a miscorrection.
- Each counter saturates independently at 2^CNT_W-1 and never wraps.
- FSM states:
  - IDLE (reset): first i_valid is accepted -> RUN.
  - RUN: accepts every i_valid. A stage-2 uncorrectable word with HALT_ON_UNCORR=1 -> HALT.
  - HALT: i_valid ignored, counters frozen. The stage-1 word already in flight when HALT is entered is discarded.
  - i_clear from any state -> IDLE.
- i_clear has priority over everything:
  - Counters, sticky, o_last_data and s1_valid are zeroed on the clock edge where i_clear is sampled high.
  - An i_valid in that cycle is dropped.
  - The in-flight stage-1 word is dropped.
- Flags with i_2bit_error set count only as uncorr, regardless of the other flags.

## Timing
- Reset values: all counters 0, o_sticky_uncorr 0, o_halted 0, o_last_data 4'h0, o_7seg 7'h3F (digit 0) with macro, 7'h00 without.
- Latency: i_valid sampled at edge N; counters, sticky and o_last_data update at edge N+1. o_halted rises at edge N+1.
- o_7seg is registered: it reflects the counter value one cycle after that counter changes, or one cycle after i_sel changes.
- Throughput: one word per cycle, back-to-back valid supported.
- Async reset mid-stream: all state returns to reset values immediately; the in-flight word is lost.

## Configuration
- SECDED_MON_7SEG_EN defined:
  - o_7seg shows the hex digit (0-F) of the low nibble of the counter selected by i_sel.
  - Standard segment map: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Not defined: o_7seg tied to 7'h00, no display registers or decode logic synthesized. All other behaviour is identical.

## Test plan
- Reset, then 5 back-to-back clean words (data == exp, flags 0) -> word=5, corr=0, uncorr=0, mismatch=0; o_last_data equals the 5th nibble.
- Word with i_1bit_error=1, data==exp, then word with i_parity_error=1 -> corr=2, mismatch=0, sticky=0.
- HALT_ON_UNCORR=1: word with i_2bit_error=1, followed by 3 more valid words -> uncorr=1, word=1 (the next word, in flight, is discarded), o_halted=1, sticky=1. Then i_clear -> all 0, IDLE, and the next word is counted.
- Word with i_1bit_error=1, data=4'hA, exp=4'h5 -> corr=1, mismatch=1. Same data mismatch with i_2bit_error=1 -> mismatch unchanged.
- CNT_W=4: 20 clean words -> word_cnt holds at 15, no wrap.
- i_clear asserted in the same cycle as i_valid -> the word is not counted. With SECDED_MON_7SEG_EN, i_sel=00 after 10 clean words gives o_7seg=7'h77 one cycle later.
